// File: rtl/jk_reg_bank_if.sv
// Control/status bus for jk_reg_bank: mode inputs, load/clear strobes and
// the registered state outputs.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] sr_err;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, j, k, load, load_val, err_clr, cnt_clr,
    input  q, qbar, sr_err, chg_cnt
  );

  modport slave (
    input  en, mode, j, k, load, load_val, err_clr, cnt_clr,
    output q, qbar, sr_err, chg_cnt
  );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH flip-flops with run-time JK/D/T/SR mode, parallel load,
// sticky SR illegal-input flags and a saturating count of output bit changes.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input logic          clk,
  input logic          rst,
  jk_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  localparam int               POP_W   = $clog2(WIDTH + 1);
  localparam int               SUM_W   = CNT_W + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  mode_e            mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] err_r;
  logic [WIDTH-1:0] err_next;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    q_next  = q_r;
    illegal = '0;
    if (bus.load) begin
      q_next = bus.load_val;
    end else if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_D: q_next[i] = bus.j[i];
          MODE_T: if (bus.j[i]) q_next[i] = ~q_r[i];
          default: begin
            // JK and SR decode identically except for the 11 combination
            case ({bus.j[i], bus.k[i]})
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              2'b11: begin
                if (mode == MODE_SR) illegal[i] = 1'b1;
                else                 q_next[i]  = ~q_r[i];
              end
              default: q_next[i] = q_r[i];
            endcase
          end
        endcase
      end
    end
  end

  // A clear and a fresh illegal event on the same bit keep the bit set
  assign err_next = bus.err_clr ? illegal : (err_r | illegal);

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(q_next[i] ^ q_r[i]);
    end
  end

  // Widened add so the clamp sees the true sum before it could wrap
  assign sum      = SUM_W'(cnt_r) + SUM_W'(pop);
  assign cnt_next = bus.cnt_clr     ? '0 :
                    (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      q_r   <= RESET_VAL;
      err_r <= '0;
      cnt_r <= '0;
    end else begin
      q_r   <= q_next;
      err_r <= err_next;
      cnt_r <= cnt_next;
    end
  end

  assign bus.q       = q_r;
  assign bus.qbar    = ~q_r;
  assign bus.sr_err  = err_r;
  assign bus.chg_cnt = cnt_r;

endmodule
